// File: rtl/clk_div_multi_if.sv
// Config request channel for clk_div_multi: one divisor write per valid&ready edge.
interface clk_div_multi_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;

  modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider. Each lane produces a registered
// square wave and a period-start strobe; divisor writes are staged in a
// pending slot and only take effect at a period boundary.

// One divider lane.
module clk_div_ch #(
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] act_div,
  output logic             pend
);
  logic             run;
  logic [DIV_W-1:0] cnt, cnt_n, div_n, pend_div;
  logic             wrap, apply;

  // Period bookkeeping: a new period begins on a wrap or on the first enabled edge.
  always_comb begin
    wrap  = run & en & (cnt == act_div - DIV_W'(1));
    // Disabled or just-starting lanes have no period in flight, so a pending divisor can land immediately.
    apply = pend & (~en | ~run | wrap);
    div_n = apply ? pend_div : act_div;
    cnt_n = '0;
    if (en && run && !wrap) cnt_n = cnt + DIV_W'(1);
  end

  // State and outputs; outputs are loaded from the next-state count so they line up with cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= 1'b0;
      cnt      <= '0;
      act_div  <= DEF_DIV;
      pend_div <= DEF_DIV;
      pend     <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      run     <= en;
      cnt     <= cnt_n;
      act_div <= div_n;
      clk_out <= en & (cnt_n < (div_n >> 1));
      tick    <= en & (cnt_n == '0);
      // wr is only possible while pend is clear, so it never collides with apply.
      if (wr) begin
        pend     <= 1'b1;
        pend_div <= wr_div;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end
endmodule

module clk_div_multi #(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 2
) (
  input  logic                           ext_clk_25m,
  input  logic                           ext_rst,
  input  logic [NUM_CH-1:0]              ch_en,
  clk_div_multi_if.slave                 cfg,
  output logic [NUM_CH-1:0]              clk_out,
  output logic [NUM_CH-1:0]              tick,
  output logic [NUM_CH-1:0][DIV_W-1:0]   cur_div
);
  localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DIV_W-1:0] DEF_EFF = (DEF_DIV < 2) ? DIV_W'(2) : DIV_W'(DEF_DIV);

  logic [NUM_CH-1:0] pend;
  logic              sel_pend;
  logic              accept;
  logic [DIV_W-1:0]  wr_div;

  // Ready follows the addressed lane's pending slot; unmapped channel codes always accept and are dropped.
  always_comb begin
    sel_pend = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (cfg.cfg_ch == CH_W'(c)) sel_pend = pend[c];
    cfg.cfg_ready = ~sel_pend & ~ext_rst;
    accept        = cfg.cfg_valid & cfg.cfg_ready;
    wr_div        = (cfg.cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg.cfg_div;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_ch #(.DIV_W(DIV_W), .DEF_DIV(DEF_EFF)) u_ch (
      .clk     (ext_clk_25m),
      .rst     (ext_rst),
      .en      (ch_en[c]),
      .wr      (accept && (cfg.cfg_ch == CH_W'(c))),
      .wr_div  (wr_div),
      .clk_out (clk_out[c]),
      .tick    (tick[c]),
      .act_div (cur_div[c]),
      .pend    (pend[c])
    );
  end
endmodule
